// File: rtl/riscv_mem_pkg.sv
// ----------------------------------------------------------------------------
// riscv_mem_pkg : funct3 codes, controller FSM states and load lane/extend helper
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT      = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_ACCESS_HI = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    // dw holds {next word, addressed word}; off selects the first byte lane.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [63:0] dw);
        logic [63:0] sh;
        sh = dw >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}},  sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_W:    return sh[31:0];
            F3_BU:   return {24'd0, sh[7:0]};
            F3_HU:   return {16'd0, sh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bank.sv
// ----------------------------------------------------------------------------
// dmem_bank : DEPTH_WORDS x 32 synchronous RAM, 4 byte-write enables, 1-cycle read
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_bank #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl : handshaked byte-addressed RV32 data memory with wait states.
//                 DMEM_MISALIGN_SPLIT_EN: word-crossing accesses run as two beats.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    state_t        state;
    logic [2:0]    wait_cnt;
    logic          hi_phase;
    logic          we_q;
    logic          err_q;
    logic          split_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   lo_word;

    logic          req_err;
    logic          req_split;
    logic          illegal;
    logic          oor;
    logic [3:0]    mask;
    logic [7:0]    be8;
    logic [63:0]   wd64;
    logic          bank_en;
    logic          beat_hi;
    logic [AW-1:0] bank_addr;
    logic [3:0]    bank_be;
    logic [31:0]   bank_wdata;
    logic [31:0]   bank_rdata;
    logic [63:0]   dw;

    // Request classification, evaluated on the live request and latched on accept.
    assign illegal = req_we ? (req_funct3 > F3_W)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign oor     = |req_addr[31:AW+2];

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic crosses;
    logic last_word;
    assign crosses   = (req_funct3[1:0] == 2'b01 && req_addr[1:0] == 2'd3) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'd0);
    assign last_word = &req_addr[AW+1:2];
    assign req_err   = illegal | oor | (crosses & last_word);
    assign req_split = crosses & ~req_err;
`else
    logic misal;
    assign misal     = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'd0);
    assign req_err   = illegal | oor | misal;
    assign req_split = 1'b0;
`endif

    assign req_ready = (state == ST_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            hi_phase <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            lo_word  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        err_q    <= req_err;
                        split_q  <= req_split;
                        f3_q     <= req_funct3;
                        off_q    <= req_addr[1:0];
                        idx_q    <= req_addr[AW+1:2];
                        wdata_q  <= req_wdata;
                        hi_phase <= 1'b0;
                        wait_cnt <= 3'd0;
                        state    <= (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        wait_cnt <= 3'd0;
                        state    <= hi_phase ? ST_ACCESS_HI : ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_ACCESS: begin
                    if (split_q) begin
                        hi_phase <= 1'b1;
                        state    <= (LATENCY == 0) ? ST_ACCESS_HI : ST_WAIT;
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_ACCESS_HI: begin
                    // Bank output still carries the low-beat word read in ACCESS.
                    lo_word <= bank_rdata;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    assign be8  = {4'b0000, mask} << off_q;
    assign wd64 = {32'd0, wdata_q} << {off_q, 3'b000};

    // rst gates the enable so an aborted access never writes, even in ACCESS.
    assign bank_en    = (state == ST_ACCESS || state == ST_ACCESS_HI) && !rst;
    assign beat_hi    = (state == ST_ACCESS_HI);
    assign bank_addr  = beat_hi ? idx_q + AW'(1) : idx_q;
    assign bank_be    = (we_q && !err_q) ? (beat_hi ? be8[7:4] : be8[3:0]) : 4'b0000;
    assign bank_wdata = beat_hi ? wd64[63:32] : wd64[31:0];

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .be    (bank_be),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    assign dw        = split_q ? {bank_rdata, lo_word} : {32'd0, bank_rdata};
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = (state == ST_RESP) && err_q;
    assign rsp_rdata = (state == ST_RESP && !we_q && !err_q) ? load_extend(f3_q, off_q, dw)
                                                             : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl : directed vector bench, LATENCY=0 and LATENCY=3 instances
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata  [2];
    logic [1:0]  rsp_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(512), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.DEPTH_WORDS(512), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        int          sel;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input int sel, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat);
        vec_t v;
        v.sel = sel; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endfunction

    // Issues one request, measures cycles from accept to rsp_valid, optionally
    // stalls the response for 'hold' cycles, then completes the handshake.
    task automatic do_req(input int sel, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        int   k;
        logic busy_ok;
        logic stable;
        rdata = 32'd0;
        err   = 1'b0;
        lat   = -1;
        @(negedge clk);
        req_valid[sel]  = 1'b1;
        req_we[sel]     = we;
        req_funct3[sel] = f3;
        req_addr[sel]   = addr;
        req_wdata[sel]  = wd;
        k = 0;
        while (!req_ready[sel] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[sel]) begin
            failures++; checks++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high");
            req_valid[sel] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[sel] = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!rsp_valid[sel] && lat < 50) begin
            if (req_ready[sel]) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready[sel]) busy_ok = 1'b0;
        check("req_ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
        if (!rsp_valid[sel]) begin
            failures++; checks++;
            $display("FAIL rsp_timeout actual=valid_low required=valid_high");
            return;
        end
        rdata  = rsp_rdata[sel];
        err    = rsp_err[sel];
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid[sel] || rsp_rdata[sel] !== rdata || rsp_err[sel] !== err ||
                req_ready[sel])
                stable = 1'b0;
        end
        if (hold > 0) check("rsp_stable_during_stall", {31'd0, stable}, 32'd1);
        rsp_ready[sel] = 1'b1;
        @(negedge clk);
        rsp_ready[sel] = 1'b0;
        check("rsp_valid_drops_after_handshake", {31'd0, rsp_valid[sel]}, 32'd0);
        check("req_ready_after_handshake", {31'd0, req_ready[sel]}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_funct3[i] = 3'd0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
        end

        // Directed vectors: sel 0 = LATENCY 0, sel 1 = LATENCY 3.
        add(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
        add(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
        add(0, 1, 3'b000, 32'h11, 32'hAABBCC7F, 32'h0,        0, 2);
        add(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD7FEF, 0, 2);
        add(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2);
        add(0, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 2);
        add(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2);
        add(0, 0, 3'b101, 32'h10, 32'h0,        32'h00007FEF, 0, 2);
        add(0, 0, 3'b000, 32'h11, 32'h0,        32'h0000007F, 0, 2);
        add(0, 1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0,        0, 2);
        add(0, 0, 3'b010, 32'h10, 32'h0,        32'h12347FEF, 0, 2);
        add(0, 0, 3'b010, 32'h802, 32'h0,       32'h0,        1, 2);
        add(0, 0, 3'b000, 32'h800, 32'h0,       32'h0,        1, 2);
        add(0, 0, 3'b100, 32'h80000010, 32'h0,  32'h0,        1, 2);
        add(0, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 2);
        add(0, 0, 3'b110, 32'h10, 32'h0,        32'h0,        1, 2);
        add(0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 2);
        add(0, 0, 3'b010, 32'h10, 32'h0,        32'h12347FEF, 0, 2);
        add(1, 1, 3'b010, 32'h40, 32'h01020304, 32'h0,        0, 5);
        add(1, 0, 3'b010, 32'h40, 32'h0,        32'h01020304, 0, 5);
        add(1, 0, 3'b010, 32'h900, 32'h0,       32'h0,        1, 5);
`ifdef DMEM_MISALIGN_SPLIT_EN
        add(0, 0, 3'b001, 32'h11, 32'h0,        32'h0000347F, 0, 2);
        add(0, 1, 3'b010, 32'h14, 32'hAAAAAAAA, 32'h0,        0, 2);
        add(0, 1, 3'b010, 32'h18, 32'hBBBBBBBB, 32'h0,        0, 2);
        add(0, 1, 3'b010, 32'h16, 32'h11223344, 32'h0,        0, 3);
        add(0, 0, 3'b010, 32'h14, 32'h0,        32'h3344AAAA, 0, 2);
        add(0, 0, 3'b010, 32'h18, 32'h0,        32'hBBBB1122, 0, 2);
        add(0, 0, 3'b010, 32'h16, 32'h0,        32'h11223344, 0, 3);
        add(0, 0, 3'b001, 32'h13, 32'h0,        32'hFFFFAA12, 0, 3);
        add(0, 1, 3'b010, 32'h7FC, 32'hCAFEF00D, 32'h0,       0, 2);
        add(0, 1, 3'b010, 32'h7FE, 32'h12345678, 32'h0,       1, 2);
        add(0, 0, 3'b010, 32'h7FC, 32'h0,       32'hCAFEF00D, 0, 2);
        add(1, 1, 3'b010, 32'h44, 32'hA0B0C0D0, 32'h0,        0, 5);
        add(1, 0, 3'b010, 32'h42, 32'h0,        32'hC0D00102, 0, 9);
`else
        add(0, 1, 3'b010, 32'h13, 32'h55555555, 32'h0,        1, 2);
        add(0, 0, 3'b010, 32'h10, 32'h0,        32'h12347FEF, 0, 2);
        add(0, 0, 3'b001, 32'h11, 32'h0,        32'h0,        1, 2);
        add(0, 1, 3'b001, 32'h13, 32'h00005555, 32'h0,        1, 2);
        add(1, 0, 3'b101, 32'h41, 32'h0,        32'h0,        1, 5);
        add(1, 0, 3'b010, 32'h42, 32'h0,        32'h0,        1, 5);
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_rsp_valid", {31'd0, rsp_valid[s]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata[s], 32'd0);
            check("reset_rsp_err",   {31'd0, rsp_err[s]}, 32'd0);
            check("reset_req_ready", {31'd0, req_ready[s]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready0", {31'd0, req_ready[0]}, 32'd1);
        check("post_reset_req_ready3", {31'd0, req_ready[1]}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].sel, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0,
                   rd, er, lt);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lt), 32'(vecs[i].exp_lat));
        end

        // LATENCY=3 with the response stalled for 4 cycles.
        do_req(1, 0, 3'b010, 32'h40, 32'h0, 4, rd, er, lt);
        check("stall_rdata", rd, 32'h01020304);
        check("stall_latency", 32'(lt), 32'd5);

        // Abort a store in its WAIT cycle (LATENCY=3 instance).
        do_req(1, 1, 3'b010, 32'h20, 32'h0BADF00D, 0, rd, er, lt);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
        req_addr[1] = 32'h20; req_wdata[1] = 32'h99999999;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_req_ready", {31'd0, req_ready[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_wait_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("abort_wait_req_ready", {31'd0, req_ready[1]}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                failures++; checks++;
                $display("FAIL abort_wait_spurious_rsp actual=1 required=0");
            end
        end
        do_req(1, 0, 3'b010, 32'h20, 32'h0, 0, rd, er, lt);
        check("abort_wait_old_value", rd, 32'h0BADF00D);

        // Abort a store in its ACCESS cycle (LATENCY=0 instance).
        do_req(0, 1, 3'b010, 32'h20, 32'h0BADF00D, 0, rd, er, lt);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h77777777;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_access_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("abort_access_req_ready", {31'd0, req_ready[0]}, 32'd1);
        do_req(0, 0, 3'b010, 32'h20, 32'h0, 0, rd, er, lt);
        check("abort_access_old_value", rd, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
